// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM request server.
package vram_pkg;

  localparam int VRAM_ADDR_W      = 16;
  localparam int VRAM_DATA_W      = 16;
  localparam int VRAM_WFIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } wreq_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vram_wfifo.sv
// Synchronous write-request FIFO with registered full flag.
module vram_wfifo
  import vram_pkg::*;
#(
  parameter int DEPTH = VRAM_WFIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wreq_t                      din,
  input  logic                       pop,
  output wreq_t                      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  wreq_t         mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q;
  logic          do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)
      cnt_d = cnt_q + CNT_ONE;
    else if (!do_push && do_pop)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CNT_FULL);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/vram_req_server.sv
// VRAM request responder: buffered writes, one pending read, writes first.
// Optional VRAM_STATS_EN adds saturating write/read completion counters.
module vram_req_server
  import vram_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int DATA_W      = VRAM_DATA_W,
  parameter int WFIFO_DEPTH = VRAM_WFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddr,
  input  logic [DATA_W-1:0] writedata,
  output logic              wr_full,
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddr,
  output logic              rd_empty,
  output logic [DATA_W-1:0] readdata,
  output logic              wr_ovf,
  output logic              rd_ovf,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t            state_q, state_d;
  wreq_t             wr_in, head;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic              wr_acc, rd_acc, fifo_pop, rd_done;
  logic              rd_want, wr_more;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_empty_q, rd_empty_d;
  logic              wr_ovf_q, wr_ovf_d;
  logic              rd_ovf_q, rd_ovf_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign wr_in    = '{addr: writeaddr, data: writedata};
  assign wr_acc   = write & ~wr_full;
  assign rd_acc   = read & ~rd_pend_q;
  assign fifo_pop = (state_q == WR_ISSUE) & mem_gnt;
  assign rd_done  = (state_q == RD_WAIT) & mem_rvalid;
  assign rd_want  = rd_pend_q | rd_acc;
  assign wr_more  = (fifo_cnt > CNT_ONE) | wr_acc;

  vram_wfifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_acc),
    .din   (wr_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (wr_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Incoming requests are looked at directly so issue starts next cycle.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty || wr_acc) state_d = WR_ISSUE;
        else if (rd_want)          state_d = RD_ISSUE;
      end
      WR_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head.addr;
        mem_wdata = head.data;
        if (mem_gnt) begin
          if (wr_more)      state_d = WR_ISSUE;
          else if (rd_want) state_d = RD_ISSUE;
          else              state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = raddr_q;
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_pend_d  = rd_pend_q;
    rd_empty_d = rd_empty_q;
    raddr_d    = raddr_q;
    rdata_d    = rdata_q;
    wr_ovf_d   = wr_ovf_q | (write & wr_full);
    rd_ovf_d   = rd_ovf_q | (read & rd_pend_q);
    if (rd_acc) begin
      rd_pend_d  = 1'b1;
      rd_empty_d = 1'b1;
      raddr_d    = readaddr;
    end
    if (rd_done) begin
      rd_pend_d  = 1'b0;
      rd_empty_d = 1'b0;
      rdata_d    = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_pend_q  <= 1'b0;
      rd_empty_q <= 1'b1;
      raddr_q    <= '0;
      rdata_q    <= '0;
      wr_ovf_q   <= 1'b0;
      rd_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_empty_q <= rd_empty_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      wr_ovf_q   <= wr_ovf_d;
      rd_ovf_q   <= rd_ovf_d;
    end
  end

  assign rd_empty = rd_empty_q;
  assign readdata = rdata_q;
  assign wr_ovf   = wr_ovf_q;
  assign rd_ovf   = rd_ovf_q;

`ifdef VRAM_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = fifo_pop ? sat_inc(wr_cnt_q) : wr_cnt_q;
    rd_cnt_d = rd_done  ? sat_inc(rd_cnt_q) : rd_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_vram_req_server.sv
// Directed bench for vram_req_server with a small memory model.
module tb_vram_req_server;

  logic        clk = 1'b0;
  logic        reset;
  logic        write, read;
  logic [15:0] writeaddr, writedata, readaddr;
  logic        wr_full, rd_empty, wr_ovf, rd_ovf;
  logic [15:0] readdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef VRAM_STATS_EN
  logic [15:0] wr_count, rd_count;
`endif

  always #5 clk = ~clk;

  vram_req_server dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .writeaddr  (writeaddr),
    .writedata  (writedata),
    .wr_full    (wr_full),
    .read       (read),
    .readaddr   (readaddr),
    .rd_empty   (rd_empty),
    .readdata   (readdata),
    .wr_ovf     (wr_ovf),
    .rd_ovf     (rd_ovf),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef VRAM_STATS_EN
    ,
    .wr_count   (wr_count),
    .rd_count   (rd_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [39:0] got,
                       input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: logs granted requests, answers reads after lat edges.
  logic [15:0] mem [256];
  logic [32:0] elog [$];
  logic        auto_rv = 1'b0;
  int          lat = 2;
  int          cnt = 0;
  logic        g;
  logic [7:0]  ga;
  logic [15:0] rd_hold;
  logic        full_seen;

  always @(posedge clk) begin
    g  = auto_rv && mem_req && mem_gnt && !mem_we;
    ga = mem_addr[7:0];
    if (mem_req && mem_gnt) begin
      elog.push_back({mem_we, mem_addr, mem_wdata});
      if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
    end
    #1;
    if (auto_rv) begin
      if (g) begin
        cnt     = lat;
        rd_hold = mem[ga];
      end else if (cnt > 0) begin
        cnt--;
      end
      mem_rvalid = (cnt == 1);
      mem_rdata  = (cnt == 1) ? rd_hold : 16'h0;
    end
  end

  always @(negedge clk) if (wr_full) full_seen = 1'b1;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [32:0] e;
  int          fall_k, falls;
  logic        prev;

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0;
    writeaddr = '0; writedata = '0; readaddr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_full", wr_full, 0);
    check("rst_rd_empty", rd_empty, 1);
    check("rst_readdata", readdata, 0);
    check("rst_wr_ovf", wr_ovf, 0);
    check("rst_rd_ovf", rd_ovf, 0);
    check("rst_mem_req", mem_req, 0);
    reset = 1'b0;

    // Four writes with gnt tied high.
    mem_gnt = 1'b1; full_seen = 1'b0; elog.delete();
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; writeaddr = 16'(i); writedata = 16'(i);
      @(negedge clk);
    end
    write = 1'b0;
    repeat (4) @(negedge clk);
    check("wr4_count", elog.size(), 4);
    for (int i = 0; i < 4 && i < elog.size(); i++) begin
      e = {1'b1, 16'(i), 16'(i)};
      check("wr4_order", elog[i], e);
    end
    check("wr4_full_seen", full_seen, 0);
    check("wr4_ovf", wr_ovf, 0);

    // Fill with gnt low, overflow, then drain.
    mem_gnt = 1'b0; elog.delete();
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; writeaddr = 16'h10 + 16'(i); writedata = 16'hA0 + 16'(i);
      @(negedge clk);
    end
    write = 1'b0;
    check("fill_full", wr_full, 1);
    check("fill_ovf0", wr_ovf, 0);
    write = 1'b1; writeaddr = 16'h50; writedata = 16'h55;
    @(negedge clk);
    check("drop_ovf", wr_ovf, 1);
    check("drop_full", wr_full, 1);
    writeaddr = 16'h99; writedata = 16'h99; mem_gnt = 1'b1;
    @(negedge clk);
    write = 1'b0;
    check("pop_full_fall", wr_full, 0);
    check("pop_one", elog.size(), 1);
    repeat (5) @(negedge clk);
    check("drain_count", elog.size(), 4);
    if (elog.size() == 4) begin
      e = {1'b1, 16'h10, 16'hA0};
      check("drain_first", elog[0], e);
      e = {1'b1, 16'h13, 16'hA3};
      check("drain_last", elog[3], e);
    end

    // Same-cycle write and read to 0x03, memory latency 2.
    do_reset();
    auto_rv = 1'b1; lat = 2; elog.delete();
    write = 1'b1; writeaddr = 16'h3; writedata = 16'h3;
    read = 1'b1; readaddr = 16'h3;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    check("wr_rd_empty0", rd_empty, 1);
    fall_k = 0; falls = 0; prev = rd_empty;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (prev && !rd_empty) begin
        falls++;
        if (fall_k == 0) fall_k = k;
      end
      prev = rd_empty;
    end
    check("wr_rd_fall_k", fall_k, 4);
    check("wr_rd_falls", falls, 1);
    check("wr_rd_data", readdata, 16'h3);
    check("wr_rd_nreq", elog.size(), 2);
    if (elog.size() == 2) begin
      check("wr_rd_first_we", elog[0][32], 1);
      e = {1'b0, 16'h3, 16'h0};
      check("wr_rd_second", elog[1], e);
    end

    // Second read while pending is dropped.
    auto_rv = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; elog.delete();
    read = 1'b1; readaddr = 16'h20;
    @(negedge clk);
    read = 1'b0;
    check("rp_empty", rd_empty, 1);
    @(negedge clk);
    read = 1'b1; readaddr = 16'h21;
    @(negedge clk);
    read = 1'b0;
    check("rp_ovf", rd_ovf, 1);
    repeat (2) @(negedge clk);
    check("rp_nreq", elog.size(), 1);
    if (elog.size() == 1) begin
      e = {1'b0, 16'h20, 16'h0};
      check("rp_addr", elog[0], e);
    end
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("rp_data", readdata, 16'hBEEF);
    check("rp_empty_low", rd_empty, 0);

    // Reset during RD_WAIT, stray rvalid afterwards.
    read = 1'b1; readaddr = 16'h30;
    @(negedge clk);
    read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("rr_empty", rd_empty, 1);
    check("rr_data", readdata, 0);
    check("rr_req", mem_req, 0);
    check("rr_ovf", rd_ovf, 0);
    read = 1'b1; readaddr = 16'h31;
    @(negedge clk);
    read = 1'b0;
    check("rr_new_req", mem_req, 1);
    check("rr_new_we", mem_we, 0);
    check("rr_new_addr", mem_addr, 16'h31);

`ifdef VRAM_STATS_EN
    do_reset();
    auto_rv = 1'b1; lat = 1;
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; writeaddr = 16'h40 + 16'(i); writedata = 16'(i);
      @(negedge clk);
    end
    write = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      read = 1'b1; readaddr = 16'h40 + 16'(i);
      @(negedge clk);
      read = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("st_wr_count", wr_count, 3);
    check("st_rd_count", rd_count, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
